// File: rtl/rfarb_pkg.sv
// rfarb_pkg: shared types and defaults for the register-file arbiter.
package rfarb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } rfarb_state_t;

   localparam int unsigned RFARB_AW_DEF   = 4;
   localparam int unsigned RFARB_DW_DEF   = 4;
   localparam int unsigned RFARB_NREQ_DEF = 2;

   // Width of an encoded requester index (at least one bit).
   function automatic int unsigned rfarb_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regfile_arbiter_if.sv
// regfile_arbiter_if: requester-side request/response bus of the arbiter.
interface regfile_arbiter_if
   import rfarb_pkg::*;
#(
   parameter int unsigned NREQ = RFARB_NREQ_DEF,
   parameter int unsigned AW   = RFARB_AW_DEF,
   parameter int unsigned DW   = RFARB_DW_DEF
);

   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_we;
   logic [NREQ*AW-1:0] req_addr1;
   logic [NREQ*AW-1:0] req_addr2;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ-1:0]    rsp_valid;
   logic [DW-1:0]      rsp_data1;
   logic [DW-1:0]      rsp_data2;

   // Requester side.
   modport master (
      output req_valid, req_we, req_addr1, req_addr2, req_wdata,
      input  req_ready, rsp_valid, rsp_data1, rsp_data2
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_we, req_addr1, req_addr2, req_wdata,
      output req_ready, rsp_valid, rsp_data1, rsp_data2
   );

endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick starting after 'last'.
module rr_picker
   import rfarb_pkg::*;
#(
   parameter int unsigned NREQ = RFARB_NREQ_DEF
) (
   input  logic [NREQ-1:0]                  req,
   input  logic [rfarb_idx_w(NREQ)-1:0]     last,
   input  logic [NREQ-1:0]                  mask,
   output logic [NREQ-1:0]                  grant,
   output logic [rfarb_idx_w(NREQ)-1:0]     idx,
   output logic                             any
);

   localparam int unsigned IW = rfarb_idx_w(NREQ);

   logic [NREQ-1:0] eligible;
   logic [IW:0]     sum;
   logic [IW-1:0]   cand;

   assign eligible = req & mask;

   // Walk last+1, last+2, ... modulo NREQ and take the first eligible one.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int k = 1; k <= int'(NREQ); k++) begin
         sum = {1'b0, last} + (IW+1)'(k);
         if (sum >= (IW+1)'(NREQ)) begin
            sum = sum - (IW+1)'(NREQ);
         end
         cand = IW'(sum);
         if (!any && eligible[cand]) begin
            any         = 1'b1;
            idx         = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin sharing of one 2R/1W register file among
// NREQ requesters. Define RFARB_WR_PRIO_EN to let writes win over reads.
module regfile_arbiter
   import rfarb_pkg::*;
#(
   parameter int unsigned NREQ = RFARB_NREQ_DEF,
   parameter int unsigned AW   = RFARB_AW_DEF,
   parameter int unsigned DW   = RFARB_DW_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   regfile_arbiter_if.slave    bus,
   output logic [AW-1:0]       rf_rr1,
   output logic [AW-1:0]       rf_rr2,
   output logic [AW-1:0]       rf_wr,
   output logic [DW-1:0]       rf_wdata,
   output logic                rf_wenable,
   input  logic [DW-1:0]       rf_out1,
   input  logic [DW-1:0]       rf_out2
);

   localparam int unsigned IW = rfarb_idx_w(NREQ);

   rfarb_state_t    state;
   logic [IW-1:0]   last;
   logic [NREQ-1:0] gnt_oh;
   logic            is_wr;

   logic [NREQ-1:0] pl_grant;
   logic [IW-1:0]   pl_idx;
   logic            pl_any;
   logic [NREQ-1:0] pk_grant;
   logic [IW-1:0]   pk_idx;
   logic            pk_any;

   // Plain round-robin pass over all valid requests.
   rr_picker #(.NREQ(NREQ)) u_pick_plain (
      .req   (bus.req_valid),
      .last  (last),
      .mask  ({NREQ{1'b1}}),
      .grant (pl_grant),
      .idx   (pl_idx),
      .any   (pl_any)
   );

`ifdef RFARB_WR_PRIO_EN
   logic [NREQ-1:0] wr_grant;
   logic [IW-1:0]   wr_idx;
   logic            wr_any;

   // Write-only pass; a hit here overrides the plain pass.
   rr_picker #(.NREQ(NREQ)) u_pick_wr (
      .req   (bus.req_valid),
      .last  (last),
      .mask  (bus.req_we),
      .grant (wr_grant),
      .idx   (wr_idx),
      .any   (wr_any)
   );

   assign pk_grant = wr_any ? wr_grant : pl_grant;
   assign pk_idx   = wr_any ? wr_idx   : pl_idx;
   assign pk_any   = pl_any;
`else
   assign pk_grant = pl_grant;
   assign pk_idx   = pl_idx;
   assign pk_any   = pl_any;
`endif

   // Grant is offered only while idle; valid & ready completes the handshake.
   assign bus.req_ready = (state == IDLE) ? pk_grant : '0;

   // Transaction FSM with registered register-file and response outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         last          <= IW'(NREQ - 1);
         gnt_oh        <= '0;
         is_wr         <= 1'b0;
         rf_rr1        <= '0;
         rf_rr2        <= '0;
         rf_wr         <= '0;
         rf_wdata      <= '0;
         rf_wenable    <= 1'b0;
         bus.rsp_valid <= '0;
         bus.rsp_data1 <= '0;
         bus.rsp_data2 <= '0;
      end else begin
         bus.rsp_valid <= '0;
         unique case (state)
            IDLE: begin
               if (pk_any) begin
                  last   <= pk_idx;
                  gnt_oh <= pk_grant;
                  is_wr  <= bus.req_we[pk_idx];
                  if (bus.req_we[pk_idx]) begin
                     rf_wenable <= 1'b1;
                     rf_wr      <= bus.req_addr1[pk_idx*AW +: AW];
                     rf_wdata   <= bus.req_wdata[pk_idx*DW +: DW];
                  end else begin
                     rf_rr1 <= bus.req_addr1[pk_idx*AW +: AW];
                     rf_rr2 <= bus.req_addr2[pk_idx*AW +: AW];
                  end
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               rf_wenable <= 1'b0;
               state      <= is_wr ? IDLE : CAPTURE;
            end
            CAPTURE: begin
               bus.rsp_data1 <= rf_out1;
               bus.rsp_data2 <= rf_out2;
               bus.rsp_valid <= gnt_oh;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Shares the single-port-pair 4-bit × 16 register file between NREQ independent requesters. It uses round-robin arbitration with a valid/ready request handshake. Each granted request becomes one read transaction (two addresses, two data words returned) or one write transaction on the register file's `rr1/rr2/wr/wdata/wenable` ports. The block sits between the requesters (sequencers or test harnesses) and the register file, and drives every register-file input.

## Interface
- `NREQ`, default 2: number of requesters, range 2–8.
- `AW`, default 4: register address width.
- `DW`, default 4: register data width.
- `clk`, in, 1: the single clock. Reset is synchronous and active-low.
- `rst_n`, in, 1: synchronous active-low reset, sampled on the `clk` rising edge.
- `req_valid`, in, NREQ: request pending, one bit per requester.
- `req_we`, in, NREQ: 1 = write, 0 = read.
- `req_addr1`, in, NREQ*AW: read address 1, or the write address when `req_we` = 1. Slice i belongs to requester i.
- `req_addr2`, in, NREQ*AW: read address 2. Ignored on writes.
- `req_wdata`, in, NREQ*DW: write data.
- `req_ready`, out, NREQ: one-hot grant. A handshake completes on a cycle with `req_valid[i] & req_ready[i]`.
- `rsp_valid`, out, NREQ: one-hot, one-cycle read-response strobe.
- `rsp_data1`, out, DW: read data for `addr1`, shared by all requesters.
- `rsp_data2`, out, DW: read data for `addr2`, shared by all requesters.
- `rf_rr1`, `rf_rr2`, `rf_wr`, out, AW: register-file address ports. All are registered.
- `rf_wdata`, out, DW: register-file write data. Registered.
- `rf_wenable`, out, 1: register-file write enable. Registered.
- `rf_out1`, `rf_out2`, in, DW: register-file read outputs. Each is valid one cycle after its address is presented with `rf_wenable` = 0.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE.
- **IDLE**
  - If any `req_valid` is set, the round-robin picker selects requester g and `req_ready[g]` = 1 combinationally. `req_ready` is 0 in every other state.
  - On the handshake edge, the block registers `rf_*` from requester g's fields and moves to ISSUE.
- **ISSUE**
  - For a write: `rf_wenable` = 1, `rf_wr`/`rf_wdata` = captured values. Next state is IDLE.
  - For a read: `rf_wenable` = 0, `rf_rr1`/`rf_rr2` = captured addresses. Next state is CAPTURE.
- **CAPTURE**
  - Registers `rf_out1`/`rf_out2` into `rsp_data1`/`rsp_data2` and sets `rsp_valid[g]` = 1 for exactly the next cycle. Next state is IDLE.
- `rf_wenable` is high only during a write's ISSUE cycle.
- `rf_rr*` hold their last value otherwise. The register file's z-output during writes is never sampled.
- Round robin:
  - A pointer `last` holds the most recently granted index.
  - Search order is `last+1`, `last+2`, … with wrap-around modulo NREQ.
  - `last` updates only on a handshake.
- Requesters hold `req_*` stable while `req_valid` is high and not yet granted. The block samples the request fields only on the handshake edge.
- `rsp_data*` hold their value until the next read capture.

## Timing
- Read: handshake at edge E0, `rf_rr*` valid after E0, register file samples at E1, capture at E2, `rsp_valid` high in the cycle after E2. Latency is 3 cycles from handshake to response; one read per 3 cycles.
- Write: handshake at E0, `rf_wenable` = 1 between E0 and E1, register file writes at E1. One write per 2 cycles.
- A read following a write to the same address returns the new data.
- Reset values: state = IDLE, `last` = NREQ-1 (requester 0 wins first), `req_ready` = 0, `rsp_valid` = 0, `rsp_data*` = 0, `rf_rr1`/`rf_rr2`/`rf_wr`/`rf_wdata` = 0, `rf_wenable` = 0.
- Reset mid-operation:
  - A pending read response is dropped.
  - If the reset edge coincides with `rf_wenable` = 1, the register-file write still happens, because the register file has no reset.
- Simultaneous requests are resolved purely by the round-robin pointer. There is no starvation: each requester waits at most NREQ-1 grants.

## Configuration
- `RFARB_WR_PRIO_EN` defined:
  - In IDLE, if any valid request has `req_we` = 1, grant goes to the first such requester in round-robin order, ahead of all reads.
  - `last` still updates on every handshake.
- Not defined: writes and reads are arbitrated identically in plain round-robin.

## Structure
- Package `rfarb_pkg`:
  - state enum `rfarb_state_t` (IDLE, ISSUE, CAPTURE);
  - constants `RFARB_AW_DEF` = 4 and `RFARB_DW_DEF` = 4.
- Sub-module `rr_picker`:
  - inputs: NREQ request vector, `last` pointer, optional mask;
  - output: one-hot grant plus encoded index;
  - purely combinational, reused for both write-priority and plain passes.

## Test plan
- **Single read:** preload R3 = 4'hA, R7 = 4'h5; requester 0 reads (3, 7) → `req_ready[0]` in the same cycle, `rsp_valid` = 2'b01 three cycles later, `rsp_data1` = A, `rsp_data2` = 5.
- **Write then read:** req 1 writes R2 = 4'hC, then reads (2, 2) → `rf_wenable` pulses for exactly one cycle; response is C/C on `rsp_valid` = 2'b10.
- **Fairness:** both requesters hold reads continuously from reset → grants alternate 0, 1, 0, 1; no two consecutive grants to the same requester.
- **Write priority (`RFARB_WR_PRIO_EN`):** `last` = 1, req 0 reads and req 1 writes simultaneously → req 1 is granted first. Without the macro, req 0 is granted first.
- **Reset mid-read:** assert `rst_n` = 0 in CAPTURE → `rsp_valid` never fires; all outputs are at reset values the next cycle; the first post-reset grant goes to requester 0.
- **Wrap/last register:** NREQ = 4, only req 3 then req 0 active; write R15 = 4'hF, read (15, 0) → correct data; grant order 3 → 0.
